sync_fifo: RTL and testbench

- Single-clock, parametrised successor to the dual-clock FIFO. Serves same-domain buffering where a CDC FIFO is unnecessary.
- Adds programmable almost-full/almost-empty thresholds, an exact fill level, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Optionally adds sticky overflow/underflow error flags.

---
 rtl/sync_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 110 +++++++++++
 tb/tb_sync_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle for sync_fifo.
// The FIFO connects to the slave modport and the producer/consumer to the master modport.
interface sync_fifo_if #(
    parameter int BITS = 32,
    parameter int SIZE = 16
);
    localparam int LW = $clog2(SIZE) + 1;

    logic            p_clear;
    logic            p_write_en;
    logic [BITS-1:0] p_write_data;
    logic            p_write_full;
    logic            p_write_almost_full;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            p_read_empty;
    logic            p_read_almost_empty;
    logic [LW-1:0]   p_level;
    logic            p_overflow;
    logic            p_underflow;

    modport master (
        output p_clear, p_write_en, p_write_data, p_read_en,
        input  p_write_full, p_write_almost_full, p_read_data, p_read_empty,
        input  p_read_almost_empty, p_level, p_overflow, p_underflow
    );

    modport slave (
        input  p_clear, p_write_en, p_write_data, p_read_en,
        output p_write_full, p_write_almost_full, p_read_data, p_read_empty,
        output p_read_almost_empty, p_level, p_overflow, p_underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, flush and optional FWFT read.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo #(
    parameter int BITS  = 32,
    parameter int SIZE  = 16,
    parameter int FWFT  = 0,
    parameter int AF_TH = SIZE - 2,
    parameter int AE_TH = 1
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave fifo_if
);
    localparam int AW = $clog2(SIZE);
    localparam int LW = AW + 1;

    logic [BITS-1:0] mem [SIZE];
    logic [AW-1:0]   writePtr_q, writePtr_d;
    logic [AW-1:0]   readPtr_q, readPtr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            isFull, isEmpty;
    logic            writeAccept, readAccept;

    assign isFull      = (level_q == LW'(SIZE));
    assign isEmpty     = (level_q == '0);
    assign writeAccept = fifo_if.p_write_en && !isFull;
    assign readAccept  = fifo_if.p_read_en && !isEmpty;

    assign fifo_if.p_write_full        = isFull;
    assign fifo_if.p_read_empty        = isEmpty;
    assign fifo_if.p_write_almost_full = (level_q >= LW'(AF_TH));
    assign fifo_if.p_read_almost_empty = (level_q <= LW'(AE_TH));
    assign fifo_if.p_level             = level_q;

    // Flush wins over any access; a simultaneous write and read leave the level unchanged.
    always_comb begin
        writePtr_d = writePtr_q;
        readPtr_d  = readPtr_q;
        level_d    = level_q;
        if (fifo_if.p_clear) begin
            writePtr_d = '0;
            readPtr_d  = '0;
            level_d    = '0;
        end else begin
            if (writeAccept) writePtr_d = writePtr_q + AW'(1);
            if (readAccept)  readPtr_d  = readPtr_q + AW'(1);
            case ({writeAccept, readAccept})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writePtr_q <= '0;
            readPtr_q  <= '0;
            level_q    <= '0;
        end else begin
            writePtr_q <= writePtr_d;
            readPtr_q  <= readPtr_d;
            level_q    <= level_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!fifo_if.p_clear && writeAccept)
            mem[writePtr_q] <= fifo_if.p_write_data;
    end

    generate
        if (FWFT != 0) begin : gFwft
            assign fifo_if.p_read_data = isEmpty ? '0 : mem[readPtr_q];
        end else begin : gStd
            logic [BITS-1:0] readData_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    readData_q <= '0;
                else if (!fifo_if.p_clear && readAccept)
                    readData_q <= mem[readPtr_q];
            end
            assign fifo_if.p_read_data = readData_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (fifo_if.p_clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo_if.p_write_en && isFull) overflow_q  <= 1'b1;
            if (fifo_if.p_read_en && isEmpty) underflow_q <= 1'b1;
        end
    end

    assign fifo_if.p_overflow  = overflow_q;
    assign fifo_if.p_underflow = underflow_q;
`else
    assign fifo_if.p_overflow  = 1'b0;
    assign fifo_if.p_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read instance and an FWFT instance share one stimulus stream.
// Expected sticky-flag values follow whether SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic [63:0] ERR = 64'd1;
`else
    localparam logic [63:0] ERR = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [31:0] sbq[$];
    logic [31:0] expRd;
    logic [31:0] lastRd0;
    logic        we, re;

    always #5 clk = ~clk;

    sync_fifo_if #(.BITS(32), .SIZE(16)) if0 ();
    sync_fifo_if #(.BITS(32), .SIZE(16)) if1 ();

    sync_fifo #(.BITS(32), .SIZE(16), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .fifo_if(if0));
    sync_fifo #(.BITS(32), .SIZE(16), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .fifo_if(if1));

    task automatic applyStimulus(input logic clr, input logic wen, input logic [31:0] wdata,
                                 input logic ren);
        if0.p_clear = clr;  if0.p_write_en = wen;  if0.p_write_data = wdata;  if0.p_read_en = ren;
        if1.p_clear = clr;  if1.p_write_en = wen;  if1.p_write_data = wdata;  if1.p_read_en = ren;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        lastRd0     = '0;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #12;
        checkOutput("rst_level",  64'(if0.p_level), 64'd0);
        checkOutput("rst_empty",  64'(if0.p_read_empty), 64'd1);
        checkOutput("rst_full",   64'(if0.p_write_full), 64'd0);
        checkOutput("rst_ae",     64'(if0.p_read_almost_empty), 64'd1);
        checkOutput("rst_af",     64'(if0.p_write_almost_full), 64'd0);
        checkOutput("rst_rdata0", 64'(if0.p_read_data), 64'd0);
        checkOutput("rst_rdata1", 64'(if1.p_read_data), 64'd0);
        checkOutput("rst_ovf",    64'(if0.p_overflow), 64'd0);
        checkOutput("rst_unf",    64'(if0.p_underflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x11..0x20; almost-full rises at level 14, full at 16
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h11 + 32'(i), 1'b0);
            tick();
            checkOutput("fill_level", 64'(if0.p_level), 64'(i + 1));
            checkOutput("fill_af",    64'(if0.p_write_almost_full), 64'(i + 1 >= 14));
            checkOutput("fill_full",  64'(if0.p_write_full), 64'(i + 1 == 16));
        end

        // Write and read together while full: read wins, 0xAA dropped
        applyStimulus(1'b0, 1'b1, 32'hAA, 1'b1);
        tick();
        checkOutput("fullrw_level",  64'(if0.p_level), 64'd15);
        checkOutput("fullrw_full",   64'(if0.p_write_full), 64'd0);
        checkOutput("fullrw_rdata0", 64'(if0.p_read_data), 64'h11);
        checkOutput("fullrw_rdata1", 64'(if1.p_read_data), 64'h12);
        checkOutput("fullrw_ovf",    64'(if0.p_overflow), ERR);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            tick();
            checkOutput("drain_rdata0", 64'(if0.p_read_data), 64'(32'h12 + 32'(i)));
            checkOutput("drain_rdata1", 64'(if1.p_read_data), (i == 14) ? 64'd0 : 64'(32'h13 + 32'(i)));
            checkOutput("drain_level",  64'(if0.p_level), 64'(14 - i));
            checkOutput("drain_ae",     64'(if0.p_read_almost_empty), 64'(14 - i <= 1));
            checkOutput("drain_empty",  64'(if0.p_read_empty), 64'(i == 14));
        end

        // Write and read together while empty: write wins, read data holds
        applyStimulus(1'b0, 1'b1, 32'h55, 1'b1);
        tick();
        checkOutput("emptyrw_level",  64'(if0.p_level), 64'd1);
        checkOutput("emptyrw_rdata0", 64'(if0.p_read_data), 64'h20);
        checkOutput("emptyrw_rdata1", 64'(if1.p_read_data), 64'h55);
        checkOutput("emptyrw_unf",    64'(if0.p_underflow), ERR);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("emptyrw_next0", 64'(if0.p_read_data), 64'h55);
        checkOutput("emptyrw_lvl0",  64'(if0.p_level), 64'd0);
        checkOutput("emptyrw_next1", 64'(if1.p_read_data), 64'h0);

        // FWFT: data appears one edge after the write with no read issued
        applyStimulus(1'b0, 1'b1, 32'h01, 1'b0);
        tick();
        checkOutput("fwft_empty", 64'(if1.p_read_empty), 64'd0);
        checkOutput("fwft_d1",    64'(if1.p_read_data), 64'h01);
        applyStimulus(1'b0, 1'b1, 32'h02, 1'b0);
        tick();
        checkOutput("fwft_hold",  64'(if1.p_read_data), 64'h01);
        checkOutput("fwft_lvl2",  64'(if1.p_level), 64'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("fwft_pop1",  64'(if1.p_read_data), 64'h02);
        checkOutput("std_pop1",   64'(if0.p_read_data), 64'h01);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("fwft_pop2e", 64'(if1.p_read_empty), 64'd1);
        checkOutput("fwft_pop2d", 64'(if1.p_read_data), 64'h0);
        checkOutput("std_pop2",   64'(if0.p_read_data), 64'h02);
        lastRd0 = 32'h02;

        // Mixed traffic with occupancy kept in 3..12, pointers wrap several times
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0);
            tick();
            sbq.push_back(32'h100 + 32'(k));
        end
        for (int n = 0; n < 40; n++) begin
            we = (sbq.size() < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            re = (sbq.size() > 3)  ? 1'($urandom_range(0, 1)) : 1'b0;
            expRd = re ? sbq[0] : lastRd0;
            applyStimulus(1'b0, we, 32'h200 + 32'(n), re);
            tick();
            if (re) void'(sbq.pop_front());
            if (we) sbq.push_back(32'h200 + 32'(n));
            lastRd0 = expRd;
            checkOutput("mix_rdata0", 64'(if0.p_read_data), 64'(expRd));
            checkOutput("mix_rdata1", 64'(if1.p_read_data), 64'(sbq[0]));
            checkOutput("mix_level",  64'(if0.p_level), 64'(sbq.size()));
        end
        checkOutput("held_ovf", 64'(if0.p_overflow), ERR);
        checkOutput("held_unf", 64'(if0.p_underflow), ERR);

        // Flush with a concurrent write: the word is dropped
        applyStimulus(1'b1, 1'b1, 32'h77, 1'b0);
        tick();
        sbq.delete();
        checkOutput("clr_level",  64'(if0.p_level), 64'd0);
        checkOutput("clr_empty",  64'(if0.p_read_empty), 64'd1);
        checkOutput("clr_rdata1", 64'(if1.p_read_data), 64'h0);
        checkOutput("clr_rdata0", 64'(if0.p_read_data), 64'(lastRd0));
        checkOutput("clr_ovf",    64'(if0.p_overflow), 64'd0);
        checkOutput("clr_unf",    64'(if0.p_underflow), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h99, 1'b0);
        tick();
        checkOutput("postclr_d1",  64'(if1.p_read_data), 64'h99);
        checkOutput("postclr_lvl", 64'(if0.p_level), 64'd1);

        // Sticky flags
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("err_rd99", 64'(if0.p_read_data), 64'h99);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("err_unf_set",  64'(if0.p_underflow), ERR);
        checkOutput("err_rd_hold",  64'(if0.p_read_data), 64'h99);
        checkOutput("err_lvl0",     64'(if0.p_level), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("err_unf_hold", 64'(if0.p_underflow), ERR);
        checkOutput("err_ovf_clr",  64'(if0.p_overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
            tick();
        end
        checkOutput("err_full",  64'(if0.p_write_full), 64'd1);
        checkOutput("err_lvl16", 64'(if0.p_level), 64'd16);
        applyStimulus(1'b0, 1'b1, 32'h3FF, 1'b0);
        tick();
        checkOutput("err_ovf_set", 64'(if0.p_overflow), ERR);
        checkOutput("err_ovf_lvl", 64'(if0.p_level), 64'd16);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("err_clr_ovf", 64'(if0.p_overflow), 64'd0);
        checkOutput("err_clr_unf", 64'(if0.p_underflow), 64'd0);
        checkOutput("err_clr_lvl", 64'(if0.p_level), 64'd0);

        // Reset asserted between edges must take effect immediately
        applyStimulus(1'b0, 1'b1, 32'hC1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'hC2, 1'b1);
        tick();
        checkOutput("pre_rst_rd0", 64'(if0.p_read_data), 64'hC1);
        checkOutput("pre_rst_lvl", 64'(if0.p_level), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_level",  64'(if0.p_level), 64'd0);
        checkOutput("arst_empty",  64'(if0.p_read_empty), 64'd1);
        checkOutput("arst_ae",     64'(if0.p_read_almost_empty), 64'd1);
        checkOutput("arst_af",     64'(if0.p_write_almost_full), 64'd0);
        checkOutput("arst_full",   64'(if0.p_write_full), 64'd0);
        checkOutput("arst_rdata0", 64'(if0.p_read_data), 64'd0);
        checkOutput("arst_rdata1", 64'(if1.p_read_data), 64'd0);
        checkOutput("arst_ovf",    64'(if0.p_overflow), 64'd0);
        checkOutput("arst_unf",    64'(if0.p_underflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("postrst_lvl", 64'(if0.p_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
